// File: rtl/pb_event_arbiter_pkg.sv
// Package pb_event_pkg: shared types for the push-button event arbiter.
//   ev_type_t    : event classification carried on the event port
//   chan_state_t : per-channel press FSM state
//   idx_width()  : width of a button index (at least 1 bit)
package pb_event_pkg;

    typedef enum logic [1:0] {
        SHORT        = 2'd0,
        LONG         = 2'd1,
        REPEAT       = 2'd2,
        LONG_RELEASE = 2'd3
    } ev_type_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        HELD  = 2'd2
    } chan_state_t;

    function automatic int unsigned idx_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pb_event_arbiter_if.sv
// Event port between the arbiter (master) and the UI/menu controller (slave).
//   ev_valid : event available on ev_btn/ev_type
//   ev_ready : consumer accepts the event when ev_valid & ev_ready
//   ev_btn   : index of the button that produced the event
//   ev_type  : SHORT / LONG / REPEAT / LONG_RELEASE
interface pb_event_arbiter_if #(
    parameter int unsigned N_BTN = 4
);
    import pb_event_pkg::*;

    localparam int unsigned BTN_W = idx_width(N_BTN);

    logic             ev_valid;
    logic             ev_ready;
    logic [BTN_W-1:0] ev_btn;
    ev_type_t         ev_type;

    modport master (output ev_valid, output ev_btn, output ev_type, input ev_ready);
    modport slave  (input ev_valid, input ev_btn, input ev_type, output ev_ready);

endinterface

// File: rtl/pb_event_arbiter_press_fsm.sv
// pb_press_fsm: one button channel's press classifier (FSM + hold counter).
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   pb_down   : 1-cycle "just pressed" pulse
//   pb_up     : 1-cycle "just released" pulse
//   post      : an event is detected this cycle (combinational, stored by the top)
//   post_type : type of the detected event
// Build option: PB_EVENT_AUTOREPEAT_EN enables REPEAT events while HELD.
module pb_press_fsm
    import pb_event_pkg::*;
#(
    parameter int unsigned CNT_W    = 24,
    parameter int unsigned LONG_CYC = 12500000,
    parameter int unsigned REP_CYC  = 2500000
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     pb_down,
    input  logic     pb_up,
    output logic     post,
    output ev_type_t post_type
);

`ifdef PB_EVENT_AUTOREPEAT_EN
    localparam bit AutoRep = 1'b1;
`else
    localparam bit AutoRep = 1'b0;
`endif

    localparam logic [CNT_W-1:0] LongLast = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] RepLast  = CNT_W'(REP_CYC - 1);

    chan_state_t      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             rep_hit;

    // Without autorepeat the HELD counter never moves, so this stays low.
    assign rep_hit = AutoRep && (cnt_q == RepLast);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pb_down) begin
                        state_q <= PRESS;
                        cnt_q   <= '0;
                    end
                end
                PRESS: begin
                    if (pb_up) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == LongLast) begin
                        state_q <= HELD;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                HELD: begin
                    if (pb_up) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (AutoRep) begin
                        cnt_q <= rep_hit ? '0 : cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // pb_up wins over the LONG/REPEAT thresholds in the same cycle.
    always_comb begin
        post      = 1'b0;
        post_type = SHORT;
        case (state_q)
            PRESS: begin
                if (pb_up) begin
                    post      = 1'b1;
                    post_type = SHORT;
                end else if (cnt_q == LongLast) begin
                    post      = 1'b1;
                    post_type = LONG;
                end
            end
            HELD: begin
                if (pb_up) begin
                    post      = 1'b1;
                    post_type = LONG_RELEASE;
                end else if (rep_hit) begin
                    post      = 1'b1;
                    post_type = REPEAT;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pb_event_arbiter.sv
// pb_event_arbiter: press classification for N_BTN debounced buttons, one pending
// event slot per button, round-robin arbitration onto a valid/ready event port.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   pb_down  : per-button 1-cycle press pulses
//   pb_up    : per-button 1-cycle release pulses
//   ev       : event port (master side of pb_event_arbiter_if)
//   ovf      : sticky per-button "event dropped, slot full"
//   ovf_clr  : 1-cycle pulse clearing all ovf bits
// Build option: PB_EVENT_AUTOREPEAT_EN (REPEAT events while held, see pb_press_fsm).
module pb_event_arbiter
    import pb_event_pkg::*;
#(
    parameter int unsigned N_BTN    = 4,
    parameter int unsigned CNT_W    = 24,
    parameter int unsigned LONG_CYC = 12500000,
    parameter int unsigned REP_CYC  = 2500000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_BTN-1:0]    pb_down,
    input  logic [N_BTN-1:0]    pb_up,
    pb_event_arbiter_if.master  ev,
    output logic [N_BTN-1:0]    ovf,
    input  logic                ovf_clr
);

    localparam int unsigned BTN_W = idx_width(N_BTN);

    logic [N_BTN-1:0] post;
    ev_type_t         post_type [N_BTN];

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        pb_press_fsm #(
            .CNT_W    (CNT_W),
            .LONG_CYC (LONG_CYC),
            .REP_CYC  (REP_CYC)
        ) u_fsm (
            .clk       (clk),
            .rst       (rst),
            .pb_down   (pb_down[i]),
            .pb_up     (pb_up[i]),
            .post      (post[i]),
            .post_type (post_type[i])
        );
    end

    logic [N_BTN-1:0] slot_valid_q;
    ev_type_t         slot_type_q [N_BTN];
    logic [N_BTN-1:0] ovf_q;
    logic [BTN_W-1:0] rr_q;
    logic             ev_valid_q;
    logic [BTN_W-1:0] ev_btn_q;
    ev_type_t         ev_type_q;

    logic             load;
    logic             found;
    logic [BTN_W-1:0] win;
    logic [BTN_W-1:0] idx;
    logic [N_BTN-1:0] drain;

    // First pending slot at or after rr_q, wrapping around.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < int'(N_BTN); k++) begin
            idx = BTN_W'((int'(rr_q) + k) % int'(N_BTN));
            if (!found && slot_valid_q[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign load  = !ev_valid_q || ev.ev_ready;
    assign drain = (load && found) ? (N_BTN'(1) << win) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_valid_q <= '0;
            ovf_q        <= '0;
            rr_q         <= '0;
            ev_valid_q   <= 1'b0;
            ev_btn_q     <= '0;
            ev_type_q    <= SHORT;
            for (int i = 0; i < int'(N_BTN); i++) begin
                slot_type_q[i] <= SHORT;
            end
        end else begin
            // A slot drained this cycle can accept a new post without overflow.
            for (int i = 0; i < int'(N_BTN); i++) begin
                if (post[i] && (!slot_valid_q[i] || drain[i])) begin
                    slot_valid_q[i] <= 1'b1;
                    slot_type_q[i]  <= post_type[i];
                end else if (drain[i]) begin
                    slot_valid_q[i] <= 1'b0;
                end
            end
            // Set term is OR-ed after the clear so a coincident overflow sticks.
            ovf_q <= (ovf_clr ? '0 : ovf_q) | (post & slot_valid_q & ~drain);
            if (load) begin
                ev_valid_q <= found;
                if (found) begin
                    ev_btn_q  <= win;
                    ev_type_q <= slot_type_q[win];
                    rr_q      <= (win == BTN_W'(N_BTN - 1)) ? '0 : win + BTN_W'(1);
                end
            end
        end
    end

    assign ev.ev_valid = ev_valid_q;
    assign ev.ev_btn   = ev_btn_q;
    assign ev.ev_type  = ev_type_q;
    assign ovf         = ovf_q;

endmodule

// File: tb/tb_pb_event_arbiter.sv
// Self-checking bench for pb_event_arbiter (N_BTN=4, LONG_CYC=20, REP_CYC=8).
// A press-age reference model predicts the event port and ovf every cycle.
module tb_pb_event_arbiter;
    import pb_event_pkg::*;

    localparam int unsigned NB = 4;
    localparam int unsigned LC = 20;
    localparam int unsigned RC = 8;
    localparam int unsigned CW = 8;
`ifdef PB_EVENT_AUTOREPEAT_EN
    localparam bit AUTOREP = 1'b1;
`else
    localparam bit AUTOREP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [NB-1:0] pb_down;
    logic [NB-1:0] pb_up;
    logic [NB-1:0] ovf;
    logic          ovf_clr;
    logic          rdy;

    pb_event_arbiter_if #(.N_BTN(NB)) ev_if ();

    pb_event_arbiter #(
        .N_BTN    (NB),
        .CNT_W    (CW),
        .LONG_CYC (LC),
        .REP_CYC  (RC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .pb_down (pb_down),
        .pb_up   (pb_up),
        .ev      (ev_if.master),
        .ovf     (ovf),
        .ovf_clr (ovf_clr)
    );

    always #5 clk = ~clk;

    // Reference model: button age since press, pending slot per button, output register.
    bit            m_pressed [NB];
    int            m_age     [NB];
    bit            m_slot_v  [NB];
    int            m_slot_t  [NB];
    bit            m_out_v;
    int            m_out_btn;
    int            m_out_t;
    int            m_rr;
    logic [NB-1:0] m_ovf;

    int n_checks = 0;
    int n_fails  = 0;
    int tally [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit r, input logic [NB-1:0] dn, input logic [NB-1:0] up,
                              input bit ready, input bit clr);
        bit post  [NB];
        int ptype [NB];
        int a;
        int win;
        if (r) begin
            for (int i = 0; i < NB; i++) begin
                m_pressed[i] = 0; m_age[i] = 0; m_slot_v[i] = 0; m_slot_t[i] = 0;
            end
            m_out_v = 0; m_out_btn = 0; m_out_t = 0; m_rr = 0; m_ovf = '0;
            return;
        end
        for (int i = 0; i < NB; i++) begin
            post[i]  = 0;
            ptype[i] = 0;
            if (!m_pressed[i]) begin
                if (dn[i]) begin
                    m_pressed[i] = 1;
                    m_age[i]     = 0;
                end
            end else begin
                a        = m_age[i] + 1;
                m_age[i] = a;
                if (up[i]) begin
                    post[i]      = 1;
                    ptype[i]     = (a <= int'(LC)) ? 0 : 3;
                    m_pressed[i] = 0;
                end else if (a == int'(LC)) begin
                    post[i]  = 1;
                    ptype[i] = 1;
                end else if (AUTOREP && a > int'(LC) && ((a - int'(LC)) % int'(RC)) == 0) begin
                    post[i]  = 1;
                    ptype[i] = 2;
                end
            end
        end
        if (!m_out_v || ready) begin
            win = -1;
            for (int k = 0; k < NB; k++) begin
                if (win < 0 && m_slot_v[(m_rr + k) % NB]) win = (m_rr + k) % NB;
            end
            if (win >= 0) begin
                m_out_v       = 1;
                m_out_btn     = win;
                m_out_t       = m_slot_t[win];
                m_slot_v[win] = 0;
                m_rr          = (win + 1) % NB;
            end else begin
                m_out_v = 0;
            end
        end
        if (clr) m_ovf = '0;
        for (int i = 0; i < NB; i++) begin
            if (post[i]) begin
                if (m_slot_v[i]) begin
                    m_ovf[i] = 1'b1;
                end else begin
                    m_slot_v[i] = 1;
                    m_slot_t[i] = ptype[i];
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("ev_valid", 32'(ev_if.ev_valid), 32'(m_out_v));
        if (m_out_v) begin
            chk("ev_btn", 32'(ev_if.ev_btn), 32'(m_out_btn));
            chk("ev_type", 32'(ev_if.ev_type), 32'(m_out_t));
        end
        chk("ovf", 32'(ovf), 32'(m_ovf));
    endtask

    task automatic cyc(input logic [NB-1:0] dn, input logic [NB-1:0] up);
        pb_down         = dn;
        pb_up           = up;
        ev_if.ev_ready  = rdy;
        model_edge(rst, dn, up, rdy, ovf_clr);
        @(posedge clk);
        #1;
        pb_down = '0;
        pb_up   = '0;
        ovf_clr = 1'b0;
        compare_all();
        if (ev_if.ev_valid === 1'b1) tally[int'(ev_if.ev_type)]++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc('0, '0);
    endtask

    initial begin
        logic [NB-1:0] dn;
        logic [NB-1:0] up;
        rst = 1'b1; pb_down = '0; pb_up = '0; ovf_clr = 1'b0; rdy = 1'b1;
        ev_if.ev_ready = 1'b1;
        idle(2);
        chk("reset_btn", 32'(ev_if.ev_btn), 32'd0);
        chk("reset_type", 32'(ev_if.ev_type), 32'd0);
        rst = 1'b0;

        // 1: SHORT on button 1, visible two cycles after release.
        cyc(4'b0010, '0);
        idle(4);
        cyc('0, 4'b0010);
        chk("t1_not_yet", 32'(ev_if.ev_valid), 32'd0);
        idle(1);
        chk("t1_valid", 32'(ev_if.ev_valid), 32'd1);
        chk("t1_btn", 32'(ev_if.ev_btn), 32'd1);
        chk("t1_type", 32'(SHORT), 32'(ev_if.ev_type));
        idle(2);

        // 2: long hold on button 2.
        for (int t = 0; t < 4; t++) tally[t] = 0;
        cyc(4'b0100, '0);
        idle(29);
        cyc('0, 4'b0100);
        idle(3);
        chk("t2_long", 32'(tally[1]), 32'd1);
        chk("t2_repeat", 32'(tally[2]), AUTOREP ? 32'd1 : 32'd0);
        chk("t2_release", 32'(tally[3]), 32'd1);
        chk("t2_short", 32'(tally[0]), 32'd0);

        // 3: simultaneous SHORTs on 0,1,3 from rr=0.
        rst = 1'b1; idle(1); rst = 1'b0;
        cyc(4'b1011, '0);
        idle(2);
        cyc('0, 4'b1011);
        idle(1);
        chk("t3_first", 32'(ev_if.ev_btn), 32'd0);
        idle(1);
        chk("t3_second", 32'(ev_if.ev_btn), 32'd1);
        idle(1);
        chk("t3_third", 32'(ev_if.ev_btn), 32'd3);
        idle(2);

        // 4: consumer stalled; repeated SHORTs on button 2 overflow its slot.
        rdy = 1'b0;
        for (int p = 0; p < 3; p++) begin
            cyc(4'b0100, '0);
            idle(2);
            cyc('0, 4'b0100);
        end
        idle(2);
        chk("t4_ovf", 32'(ovf), 32'b0100);
        chk("t4_hold_btn", 32'(ev_if.ev_btn), 32'd2);
        chk("t4_hold_valid", 32'(ev_if.ev_valid), 32'd1);
        ovf_clr = 1'b1;
        cyc('0, '0);
        chk("t4_ovf_clr", 32'(ovf), 32'd0);
        rdy = 1'b1;
        idle(4);

        // 5: reset during a press discards it.
        cyc(4'b0001, '0);
        idle(3);
        rst = 1'b1;
        cyc('0, '0);
        rst = 1'b0;
        chk("t5_valid_after_rst", 32'(ev_if.ev_valid), 32'd0);
        cyc('0, 4'b0001);
        idle(3);
        chk("t5_no_event", 32'(ev_if.ev_valid), 32'd0);

        // 6: down+up together while pressed -> SHORT, then IDLE ignores pb_up.
        cyc(4'b1000, '0);
        idle(3);
        cyc(4'b1000, 4'b1000);
        idle(1);
        chk("t6_btn", 32'(ev_if.ev_btn), 32'd3);
        chk("t6_type", 32'(ev_if.ev_type), 32'(SHORT));
        cyc('0, 4'b1000);
        idle(3);
        chk("t6_ignored_up", 32'(ev_if.ev_valid), 32'd0);

        // Random traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < NB; i++) begin
                dn[i] = ($urandom_range(0, 11) == 0);
                up[i] = ($urandom_range(0, 29) == 0);
                if (!m_pressed[i] && dn[i]) up[i] = 1'b0;
            end
            rdy     = ($urandom_range(0, 3) != 0);
            ovf_clr = ($urandom_range(0, 59) == 0);
            cyc(dn, up);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
